gdp_scheduler: RTL
==================

# gdp_scheduler

Sequencer for the `gdp` Gaussian distribution probability pipeline. It holds one observation vector and, on `start`, streams every component of that vector through `gdp` once per HMM state. For each component it supplies the matching mean and omega, and it supplies each state's K. It collects the resulting ln(P) values in state order and reports them as a result stream. It sits between the observation front end and the Viterbi stage.

## Interface
- `N_COMP`, default 39: observation vector length, at least 2.
- `N_STATES`, default 8: number of HMM states scored per observation.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `obs_wr`  in  1  write strobe for the observation buffer; accepted only in IDLE.
- `obs_addr`  in  $clog2(N_COMP)  component index for `obs_wr`.
- `obs_data`  in  16  observation component value.
- `start`  in  1  begin scoring; sampled only in IDLE.
- `param_addr`  out  $clog2(N_STATES*N_COMP)  mean/omega ROM address.
- `k_addr`  out  $clog2(N_STATES)  K ROM address.
- `mean_in`, `omega_in`, `k_in`  in  16 each  ROM data; each ROM has 1-cycle read latency.
- `x`, `mean`, `omega`, `k`  out  16 each  operands to `gdp`.
- `first_calc`, `last_calc`  out  1 each  `gdp` framing flags.
- `ln_p`  in  16  `gdp` result.
- `data_ready`  in  1  `gdp` result strobe.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `result_valid`  out  1  one-cycle strobe per state result.
- `result_state`  out  $clog2(N_STATES)  state index of the current result.
- `result_data`  out  16  registered copy of `ln_p`.
- `done`  out  1  one-cycle pulse, coincident with the last `result_valid`.

## Operation
- FSM states are IDLE, ISSUE, DRAIN.
- **IDLE → ISSUE** when `start` is high. Counters reset to s=0, c=0. A `start` pulse in any other state is ignored.
- **ISSUE** runs one component per cycle, with no gaps, including across state boundaries:
  - `param_addr` = s*N_COMP+c; `k_addr` = s.
  - c increments each cycle and wraps to 0 after N_COMP-1; on the wrap, s increments.
  - After (s,c) = (N_STATES-1, N_COMP-1) is issued, go to DRAIN.
- **Operand alignment.** One cycle after the address is issued, the block drives:
  - `x` = obs[c] and `mean`/`omega` = ROM data.
  - `first_calc` = (c==0) and `last_calc` = (c==N_COMP-1).
  - `k` = `k_in` when `last_calc` is high, else 0.
  - All operands and flags are 0 when no issue is in flight.
- **Result capture** in any state: on `data_ready`, register `ln_p` into `result_data`, drive `result_state` from a result counter r, pulse `result_valid` on the next cycle, and increment r.
- **DRAIN → IDLE** when the N_STATES-th result is presented; `done` pulses in that cycle.
- The block counts `data_ready` pulses and does not depend on the exact `gdp` latency.
- An extra `data_ready` in IDLE is dropped.
- `obs_wr` outside IDLE is ignored, so the buffer is stable for the whole scoring run.
- An `obs_addr` ≥ N_COMP is ignored.

## Timing
- **Reset** (asynchronous, while `reset`=0):
  - FSM = IDLE; all counters = 0.
  - `busy`, `result_valid`, `done`, `first_calc`, `last_calc` = 0.
  - All 16-bit outputs and both address outputs = 0.
  - The observation buffer contents are not cleared.
- **Reset mid-run** aborts immediately. No `done` is produced and no further results are reported.
- **Cycle numbering:** `start` is sampled at edge 0.
  - Edge 1: ISSUE begins with addr 0; `busy` = 1.
  - Edge 2: first operands with `first_calc` = 1.
  - Last operands appear N_STATES*N_COMP cycles after edge 2 minus 1.
- **Latency:** with `gdp` latency L (currently 4, from `last_calc` to `data_ready`), `done` comes L+1 cycles after the final `last_calc`.
- **Simultaneous events:** `data_ready` for state s and `last_calc` for state s+1 in the same cycle is a normal case; both must be handled.

## Structure
- Shared package `p3p_pkg` holds:
  - `DATA_W` = 16.
  - The `gdp_sched_state_t` enum {IDLE, ISSUE, DRAIN}.
- Sub-module `gdp_obs_buf`: N_COMP×16 register file with a synchronous write port and an asynchronous read port, plus a write-enable gate driven by `idle`.
- Top level: FSM, the s/c/r counters, the alignment pipeline register, and the result register.

## Test plan
Benches use N_COMP=4, N_STATES=3, a behavioural 1-cycle ROM with mean = 0x1000+addr, omega = 0x0020+addr, K = 0x17C0+state, and a `gdp` model with latency 4.
- **Full run:** load obs {0xDABE, 0x00C1, 0x0010, 0x0020}, pulse `start`.
  - 12 operand cycles with `first_calc` on components 0, 4, 8 and `last_calc` on 3, 7, 11.
  - `k` is 0x17C0/1/2 on the `last_calc` cycles and 0 elsewhere.
  - Results arrive for states 0, 1, 2 in order; `done` goes high with the third `result_valid`.
- **Busy protection:** `start` and `obs_wr` during ISSUE have no effect; buffer readback and result count (3) are unchanged.
- **Reset mid-ISSUE:** assert `reset`=0 at operand cycle 6.
  - All outputs are 0 immediately.
  - No `result_valid` or `done` follows.
  - A subsequent `start` gives a full correct run.
- **Back-to-back runs:** `start` the cycle after `done`; the second run is identical to the first.
- **Latency independence:** `gdp` model latency changed to 7; results and order are the same, and `done` comes 8 cycles after the final `last_calc`.
- **Spurious result:** `data_ready` in IDLE produces no `result_valid`, and the counter r stays 0.

Source files
------------

// File: rtl/p3p_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | p3p_pkg                                                            |
// | Shared widths and the gdp_scheduler state encoding.               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package p3p_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } gdp_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/gdp_obs_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gdp_obs_buf                                                        |
// | Observation register file: synchronous write, asynchronous read.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module gdp_obs_buf
  import p3p_pkg::*;
#(
  parameter int N_COMP = 39,
  parameter int AW     = $clog2(N_COMP)
) (
  input  logic              clk,
  input  logic              i_idle,
  input  logic              i_wr,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [N_COMP];
  logic              w_we;

  // Writes only land while idle so the vector is frozen for a whole scoring run.
  assign w_we = i_wr & i_idle & ({1'b0, i_waddr} < (AW+1)'(N_COMP));

  always_ff @(posedge clk) begin
    if (w_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/gdp_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gdp_scheduler                                                      |
// | Streams the observation vector through gdp once per HMM state and  |
// | collects the per-state ln(P) results in order.                     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module gdp_scheduler
  import p3p_pkg::*;
#(
  parameter int N_COMP   = 39,
  parameter int N_STATES = 8,
  localparam int CW = $clog2(N_COMP),
  localparam int SW = (N_STATES > 1) ? $clog2(N_STATES) : 1,
  localparam int PW = $clog2(N_STATES * N_COMP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              obs_wr,
  input  logic [CW-1:0]     obs_addr,
  input  logic [DATA_W-1:0] obs_data,
  input  logic              start,
  output logic [PW-1:0]     param_addr,
  output logic [SW-1:0]     k_addr,
  input  logic [DATA_W-1:0] mean_in,
  input  logic [DATA_W-1:0] omega_in,
  input  logic [DATA_W-1:0] k_in,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] mean,
  output logic [DATA_W-1:0] omega,
  output logic [DATA_W-1:0] k,
  output logic              first_calc,
  output logic              last_calc,
  input  logic [DATA_W-1:0] ln_p,
  input  logic              data_ready,
  output logic              busy,
  output logic              result_valid,
  output logic [SW-1:0]     result_state,
  output logic [DATA_W-1:0] result_data,
  output logic              done
);

  gdp_sched_state_t r_state, w_state_nxt;

  logic [SW-1:0]     r_s, r_r;
  logic [CW-1:0]     r_c;
  logic [PW-1:0]     r_pa;
  logic              w_issue, w_idle, w_start, w_c_wrap, w_s_last, w_accept, w_r_last;

  logic              r_iss_v, r_iss_first, r_iss_last;
  logic [CW-1:0]     r_iss_c;
  logic [PW-1:0]     r_param_addr;
  logic [SW-1:0]     r_k_addr;

  logic              r_op_v, r_op_first, r_op_last;
  logic [DATA_W-1:0] r_op_x;
  logic [DATA_W-1:0] w_obs_rd;

  logic              r_busy, r_result_valid, r_done;
  logic [SW-1:0]     r_result_state;
  logic [DATA_W-1:0] r_result_data;

  assign w_idle   = (r_state == IDLE);
  assign w_issue  = (r_state == ISSUE);
  assign w_start  = w_idle & start;
  assign w_c_wrap = (r_c == CW'(N_COMP - 1));
  assign w_s_last = (r_s == SW'(N_STATES - 1));
  assign w_accept = data_ready & ~w_idle;
  assign w_r_last = (r_r == SW'(N_STATES - 1));

  gdp_obs_buf #(
    .N_COMP (N_COMP),
    .AW     (CW)
  ) u_obs_buf (
    .clk     (clk),
    .i_idle  (w_idle),
    .i_wr    (obs_wr),
    .i_waddr (obs_addr),
    .i_wdata (obs_data),
    .i_raddr (r_iss_c),
    .o_rdata (w_obs_rd)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ISSUE;
      ISSUE:   if (w_c_wrap && w_s_last) w_state_nxt = DRAIN;
      DRAIN:   if (r_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM and s/c counters; r_pa tracks s*N_COMP+c without a multiplier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_c     <= '0;
      r_pa    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_s  <= '0;
        r_c  <= '0;
        r_pa <= '0;
      end else if (w_issue) begin
        if (w_c_wrap) begin
          r_c <= '0;
          r_s <= w_s_last ? '0 : r_s + 1'b1;
        end else begin
          r_c <= r_c + 1'b1;
        end
        r_pa <= (w_c_wrap && w_s_last) ? '0 : r_pa + 1'b1;
      end
    end
  end

  // Two-stage alignment: addresses out, then operands meet the 1-cycle ROM data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iss_v      <= 1'b0;
      r_iss_first  <= 1'b0;
      r_iss_last   <= 1'b0;
      r_iss_c      <= '0;
      r_param_addr <= '0;
      r_k_addr     <= '0;
      r_op_v       <= 1'b0;
      r_op_first   <= 1'b0;
      r_op_last    <= 1'b0;
      r_op_x       <= '0;
    end else begin
      r_iss_v      <= w_issue;
      r_iss_first  <= w_issue && (r_c == '0);
      r_iss_last   <= w_issue && w_c_wrap;
      r_iss_c      <= w_issue ? r_c : '0;
      r_param_addr <= w_issue ? r_pa : '0;
      r_k_addr     <= w_issue ? r_s : '0;
      r_op_v       <= r_iss_v;
      r_op_first   <= r_iss_first;
      r_op_last    <= r_iss_last;
      r_op_x       <= r_iss_v ? w_obs_rd : '0;
    end
  end

  // Results are counted by strobe, so gdp latency does not matter here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r            <= '0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
      r_result_state <= '0;
      r_result_data  <= '0;
    end else begin
      r_busy         <= ~w_idle && (w_state_nxt != IDLE);
      r_result_valid <= w_accept;
      r_done         <= w_accept && w_r_last;
      if (w_start) begin
        r_r <= '0;
      end else if (w_accept) begin
        r_result_data  <= ln_p;
        r_result_state <= r_r;
        r_r            <= w_r_last ? '0 : r_r + 1'b1;
      end
    end
  end

  assign param_addr   = r_param_addr;
  assign k_addr       = r_k_addr;
  assign x            = r_op_x;
  assign mean         = r_op_v ? mean_in : '0;
  assign omega        = r_op_v ? omega_in : '0;
  assign k            = r_op_last ? k_in : '0;
  assign first_calc   = r_op_first;
  assign last_calc    = r_op_last;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign result_state = r_result_state;
  assign result_data  = r_result_data;
  assign done         = r_done;

endmodule
`default_nettype wire
